// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: pool FSM encoding, default widths,
// per-layer feature-map sizes and a signed-max helper.
package cnn_pkg;

  localparam int DATA_W_DEF = 16;

  localparam int CONV1_OUT_W = 24;
  localparam int CONV1_OUT_H = 24;
  localparam int CONV2_OUT_W = 8;
  localparam int CONV2_OUT_H = 8;

  localparam logic [1:0] POOL_IDLE  = 2'd0;
  localparam logic [1:0] POOL_RUN   = 2'd1;
  localparam logic [1:0] POOL_DRAIN = 2'd2;
  localparam logic [1:0] POOL_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = POOL_IDLE,
    S_RUN   = POOL_RUN,
    S_DRAIN = POOL_DRAIN,
    S_DONE  = POOL_DONE
  } pool_state_e;

  // Wide enough for any pixel width; callers sign-extend in and truncate out.
  localparam int SMAX_W = 64;

  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-width line buffer holding the horizontal maxima of the even row
// until the matching odd row arrives; one shared index for write and read.
module pool_linebuf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 12,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic signed [DATA_W-1:0] wdata,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over one raster-order channel,
// with a single output register and a one-cycle done pulse per frame.
module maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = CONV1_OUT_W,
  parameter int IMG_H  = CONV1_OUT_H
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int LB_N = IMG_W / 2;
  localparam int IW   = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  pool_state_e state, state_nxt;

  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] vmax;
  logic signed [DATA_W-1:0] lb_rdata;
  logic [IW-1:0]            lb_idx;
  logic                     xfer;
  logic                     out_xfer;
  logic                     last_pix;
  logic                     lb_we;
  logic                     res_load;

  assign in_ready = (state == S_RUN) && !(out_valid && !out_ready);
  assign xfer     = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  assign hmax     = DATA_W'(smax(SMAX_W'(hold), SMAX_W'(in_data)));
  assign vmax     = DATA_W'(smax(SMAX_W'(hmax), SMAX_W'(lb_rdata)));
  assign lb_idx   = IW'(col >> 1);
  assign lb_we    = xfer && col[0] && !row[0];
  assign res_load = xfer && col[0] && row[0];

  pool_linebuf #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_N),
    .IDX_W  (IW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .idx   (lb_idx),
    .wdata (hmax),
    .rdata (lb_rdata)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (xfer && last_pix) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Only the final result can be pending here: the last pixel could
        // not transfer while an older result was still held.
        busy = 1'b1;
        if (out_xfer) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (xfer) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row != ROW_LAST) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // A new result wins over an accept in the same cycle.
      if (res_load) begin
        out_valid <= 1'b1;
        out_data  <= vmax;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && !col[0]) hold <= in_data;
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream on a 4x4 frame: directed and randomized frames
// compared against a window-max reference model.
module tb_maxpool2x2_stream;

  localparam int DW   = 16;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_ready = 1'b0;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maxpool2x2_stream #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Each output is the maximum of its 2x2 window, windows in raster order.
  function automatic void model(input int pix[NPIX], output int expv[NOUT]);
    for (int wr = 0; wr < H / 2; wr++) begin
      for (int wc = 0; wc < W / 2; wc++) begin
        int m;
        m = pix[(2 * wr) * W + 2 * wc];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (pix[(2 * wr + dr) * W + 2 * wc + dc] > m)
              m = pix[(2 * wr + dr) * W + 2 * wc + dc];
        expv[wr * (W / 2) + wc] = m;
      end
    end
  endfunction

  // rmode: 0 = always ready, 1 = 5-cycle stall on first result, 2 = random.
  // Returns at the negedge of the done cycle, or right after abort_at pixels.
  task automatic run_frame(input string tag, input int pix[NPIX], input int vpct,
                           input int rmode, input bit mid_start, input int abort_at);
    int expv[NOUT];
    int got[$];
    int idx = 0;
    int cyc = 0;
    int last_out_cyc = -10;
    int stall_left = 0;
    int busy_bad = 0;
    bit stalled = 1'b0;
    bit mid_done = 1'b0;
    bit done_seen = 1'b0;
    logic signed [31:0] g;

    model(pix, expv);
    @(negedge clk);
    chk({tag, "_done_low_before_start"}, done, 0);
    start = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;

    while (!done_seen && cyc < 400) begin
      if (abort_at > 0 && idx >= abort_at) break;
      start = 1'b0;
      if (mid_start && !mid_done && idx == 5) begin
        start = 1'b1;
        mid_done = 1'b1;
      end
      if (rmode == 1 && !stalled && out_valid) begin
        stalled = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) out_ready = 1'b0;
      else if (rmode == 2) out_ready = 1'($urandom_range(1));
      else out_ready = 1'b1;
      in_valid = (idx < NPIX) && ($urandom_range(99) < vpct);
      in_data = (idx < NPIX) ? DW'(pix[idx]) : '0;
      #1;
      if (stall_left > 0) begin
        chk({tag, "_stall_in_ready"}, in_ready, 0);
        chk({tag, "_stall_out_data"}, out_data, expv[0]);
        stall_left--;
      end
      if (done) begin
        done_seen = 1'b1;
        chk({tag, "_done_cycle"}, cyc, last_out_cyc + 1);
        chk({tag, "_outs_at_done"}, got.size(), NOUT);
        chk({tag, "_busy_at_done"}, busy, 0);
        break;
      end
      if (!busy) busy_bad++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got.push_back(int'(out_data));
        last_out_cyc = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;

    if (abort_at > 0) begin
      chk({tag, "_no_done_before_abort"}, done_seen, 0);
    end else begin
      chk({tag, "_done_seen"}, done_seen, 1);
      chk({tag, "_busy_gaps"}, busy_bad, 0);
      for (int i = 0; i < NOUT; i++) begin
        g = 'x;
        if (i < got.size()) g = got[i];
        chk($sformatf("%s_out%0d", tag, i), g, expv[i]);
      end
    end
  endtask

  initial begin
    int p[NPIX];
    int done_cnt;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NPIX; i++) p[i] = i;
    run_frame("ramp", p, 100, 0, 1'b0, 0);

    for (int i = 0; i < NPIX; i++) p[i] = -8;
    p[1 * W + 2] = -3;
    run_frame("signed", p, 100, 0, 1'b0, 0);

    for (int i = 0; i < NPIX; i++) p[i] = i;
    run_frame("backpressure", p, 100, 1, 1'b0, 0);
    run_frame("throttled", p, 50, 0, 1'b0, 0);
    run_frame("start_in_run", p, 100, 0, 1'b1, 0);

    for (int i = 0; i < NPIX; i++) p[i] = $urandom_range(65535) - 32768;
    run_frame("back_to_back", p, 100, 0, 1'b0, 0);

    for (int i = 0; i < NPIX; i++) p[i] = i;
    run_frame("abort", p, 100, 0, 1'b0, 6);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", done_cnt, 0);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        if (f == 0) p[i] = $urandom_range(7) - 4;
        else p[i] = $urandom_range(65535) - 32768;
      end
      run_frame($sformatf("random%0d", f), p, 60, 2, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
